// File: rtl/ddr2_rd_data_fifo_multi.sv
`default_nettype none
// ============================================================================
// Module   : ddr2_rd_data_fifo_multi
// Purpose  : Per-strobe-group rise/fall read-data FIFOs that realign DDR2
//            capture data across groups into one word, with a per-group
//            half-order swap.
// Revision : 1.0 - initial release
// ============================================================================
module ddr2_rd_data_fifo_multi #(
  parameter int DQS_GROUPS = 2,
  parameter int DQ_PER_DQS = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DQS_GROUPS-1:0]              read_en_delayed_rise,
  input  logic [DQS_GROUPS-1:0]              read_en_delayed_fall,
  input  logic [DQS_GROUPS-1:0]              first_rising,
  input  logic [DQS_GROUPS*DQ_PER_DQS-1:0]   read_data_rise,
  input  logic [DQS_GROUPS*DQ_PER_DQS-1:0]   read_data_fall,
  output logic                               read_data_valid,
  output logic [DQS_GROUPS*DQ_PER_DQS-1:0]   read_data_fifo_rise,
  output logic [DQS_GROUPS*DQ_PER_DQS-1:0]   read_data_fifo_fall,
  output logic                               fifo_empty,
  output logic                               overflow
);

  localparam int c_G     = DQS_GROUPS;
  localparam int c_W     = DQ_PER_DQS;
  localparam int c_AW    = DEPTH_LOG2;
  localparam int c_PW    = DEPTH_LOG2 + 1;
  localparam int c_DEPTH = 1 << DEPTH_LOG2;
  localparam logic [c_PW-1:0] c_FULL_XOR = {1'b1, {c_AW{1'b0}}};

  (* keep = "true" *) logic r_reset_r1;
  logic [c_PW-1:0] r_rd_ptr;
  logic [c_G-1:0]  w_empty_rise, w_empty_fall;
  logic [c_G-1:0]  w_ovf_rise, w_ovf_fall;
  logic            w_pop;
  logic            r_s1_valid;
  logic            r_valid;
  logic            r_overflow;

  always_ff @(posedge clk) begin
    r_reset_r1 <= reset;
  end

  // Pop only when every FIFO holds data at the start of the cycle.
  assign w_pop      = ~(|w_empty_rise) & ~(|w_empty_fall);
  assign fifo_empty = (|w_empty_rise) | (|w_empty_fall);

  always_ff @(posedge clk) begin
    if (r_reset_r1) begin
      r_rd_ptr   <= '0;
      r_s1_valid <= 1'b0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PW'(1);
      end
      r_s1_valid <= w_pop;
      r_valid    <= r_s1_valid;
      if ((|w_ovf_rise) | (|w_ovf_fall)) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign read_data_valid = r_valid;
  assign overflow        = r_overflow;

  for (genvar g = 0; g < c_G; g++) begin : g_group
    logic [c_W-1:0]  r_mem_rise [c_DEPTH];
    logic [c_W-1:0]  r_mem_fall [c_DEPTH];
    logic [c_PW-1:0] r_wr_ptr_rise, r_wr_ptr_fall;
    logic            w_full_rise, w_full_fall;
    logic            w_wr_rise, w_wr_fall;
    logic [c_W-1:0]  r_s1_rise, r_s1_fall;
    logic [c_W-1:0]  r_out_rise, r_out_fall;

    assign w_full_rise     = (r_wr_ptr_rise ^ r_rd_ptr) == c_FULL_XOR;
    assign w_full_fall     = (r_wr_ptr_fall ^ r_rd_ptr) == c_FULL_XOR;
    assign w_empty_rise[g] = (r_wr_ptr_rise == r_rd_ptr);
    assign w_empty_fall[g] = (r_wr_ptr_fall == r_rd_ptr);
    assign w_wr_rise       = read_en_delayed_rise[g] & ~w_full_rise;
    assign w_wr_fall       = read_en_delayed_fall[g] & ~w_full_fall;
    assign w_ovf_rise[g]   = read_en_delayed_rise[g] & w_full_rise;
    assign w_ovf_fall[g]   = read_en_delayed_fall[g] & w_full_fall;

    // Storage is left uninitialised; only the pointers define occupancy.
    always_ff @(posedge clk) begin
      if (w_wr_rise) begin
        r_mem_rise[r_wr_ptr_rise[c_AW-1:0]] <= read_data_rise[g*c_W +: c_W];
      end
      if (w_wr_fall) begin
        r_mem_fall[r_wr_ptr_fall[c_AW-1:0]] <= read_data_fall[g*c_W +: c_W];
      end
      if (w_pop) begin
        r_s1_rise <= r_mem_rise[r_rd_ptr[c_AW-1:0]];
        r_s1_fall <= r_mem_fall[r_rd_ptr[c_AW-1:0]];
      end
    end

    always_ff @(posedge clk) begin
      if (r_reset_r1) begin
        r_wr_ptr_rise <= '0;
        r_wr_ptr_fall <= '0;
        r_out_rise    <= '0;
        r_out_fall    <= '0;
      end else begin
        if (w_wr_rise) begin
          r_wr_ptr_rise <= r_wr_ptr_rise + c_PW'(1);
        end
        if (w_wr_fall) begin
          r_wr_ptr_fall <= r_wr_ptr_fall + c_PW'(1);
        end
        if (r_s1_valid) begin
          if (first_rising[g]) begin
            r_out_rise <= r_s1_fall;
            r_out_fall <= r_s1_rise;
          end else begin
            r_out_rise <= r_s1_rise;
            r_out_fall <= r_s1_fall;
          end
        end
      end
    end

    assign read_data_fifo_rise[g*c_W +: c_W] = r_out_rise;
    assign read_data_fifo_fall[g*c_W +: c_W] = r_out_fall;
  end

endmodule
`default_nettype wire

// File: tb/tb_ddr2_rd_data_fifo_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr2_rd_data_fifo_multi
// Purpose  : Scoreboard bench for ddr2_rd_data_fifo_multi (G=2, W=8, D=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ddr2_rd_data_fifo_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  en_r, en_f, fr;
  logic [15:0] dr, df;
  logic        read_data_valid;
  logic [15:0] out_rise, out_fall;
  logic        fifo_empty;
  logic        overflow;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  ddr2_rd_data_fifo_multi #(
    .DQS_GROUPS(2),
    .DQ_PER_DQS(8),
    .DEPTH_LOG2(4)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .read_en_delayed_rise (en_r),
    .read_en_delayed_fall (en_f),
    .first_rising         (fr),
    .read_data_rise       (dr),
    .read_data_fall       (df),
    .read_data_valid      (read_data_valid),
    .read_data_fifo_rise  (out_rise),
    .read_data_fifo_fall  (out_fall),
    .fifo_empty           (fifo_empty),
    .overflow             (overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected word {rise, fall} after the per-group swap.
  function automatic logic [31:0] model(input logic [15:0] r, input logic [15:0] f,
                                         input logic [1:0] sel);
    logic [15:0] o_r;
    logic [15:0] o_f;
    o_r = '0;
    o_f = '0;
    for (int g = 0; g < 2; g++) begin
      if (sel[g]) begin
        o_r[g*8 +: 8] = f[g*8 +: 8];
        o_f[g*8 +: 8] = r[g*8 +: 8];
      end else begin
        o_r[g*8 +: 8] = r[g*8 +: 8];
        o_f[g*8 +: 8] = f[g*8 +: 8];
      end
    end
    return {o_r, o_f};
  endfunction

  // Drive one cycle of stimulus; returns at the following negedge.
  task automatic cyc(input logic [1:0] er, input logic [1:0] ef,
                     input logic [15:0] r, input logic [15:0] f);
    en_r = er;
    en_f = ef;
    dr   = r;
    df   = f;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (read_data_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got rise=0x%0h fall=0x%0h, expected no valid",
                 out_rise, out_fall);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({out_rise, out_fall} !== mon_exp) begin
          errors++;
          $display("FAIL data_word: got 0x%0h, expected 0x%0h", {out_rise, out_fall}, mon_exp);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    en_r  = '0;
    en_f  = '0;
    fr    = '0;
    dr    = '0;
    df    = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", read_data_valid, 0);
    chk("rst_rise", out_rise, 0);
    chk("rst_fall", out_fall, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_overflow", overflow, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single aligned word, no swap
    exp_q.push_back(32'h2211_BBAA);
    cyc(2'b11, 2'b11, 16'h2211, 16'hBBAA);
    chk("t1_empty_after_wr", fifo_empty, 0);
    chk("t1_valid_e", read_data_valid, 0);
    cyc(2'b00, 2'b00, 16'h0, 16'h0);
    chk("t1_valid_e1", read_data_valid, 0);
    cyc(2'b00, 2'b00, 16'h0, 16'h0);
    chk("t1_valid_e2", read_data_valid, 1);
    cyc(2'b00, 2'b00, 16'h0, 16'h0);
    chk("t1_valid_pulse", read_data_valid, 0);
    chk("t1_hold_rise", out_rise, 32'h2211);
    chk("t1_hold_fall", out_fall, 32'hBBAA);

    // Group 0 swapped
    fr = 2'b01;
    exp_q.push_back(32'h22AA_BB11);
    cyc(2'b11, 2'b11, 16'h2211, 16'hBBAA);
    cyc(2'b00, 2'b00, 16'h0, 16'h0);
    cyc(2'b00, 2'b00, 16'h0, 16'h0);
    chk("t2_valid", read_data_valid, 1);
    cyc(2'b00, 2'b00, 16'h0, 16'h0);
    fr = 2'b00;

    // Group 1 arrives two cycles after group 0
    cyc(2'b01, 2'b01, 16'h0033, 16'h00CC);
    chk("t3_empty_g0", fifo_empty, 1);
    chk("t3_valid_a", read_data_valid, 0);
    cyc(2'b00, 2'b00, 16'h0, 16'h0);
    chk("t3_empty_wait", fifo_empty, 1);
    chk("t3_valid_b", read_data_valid, 0);
    exp_q.push_back(32'h4433_DDCC);
    cyc(2'b10, 2'b10, 16'h4400, 16'hDD00);
    chk("t3_empty_g1", fifo_empty, 0);
    chk("t3_valid_c", read_data_valid, 0);
    cyc(2'b00, 2'b00, 16'h0, 16'h0);
    cyc(2'b00, 2'b00, 16'h0, 16'h0);
    chk("t3_valid", read_data_valid, 1);
    cyc(2'b00, 2'b00, 16'h0, 16'h0);

    // Overflow on group 0 rise; the dropped 0xEE must never appear
    for (int i = 0; i < 16; i++) begin
      cyc(2'b01, 2'b00, {8'h00, 8'(8'h50 + i)}, 16'h0);
    end
    chk("t4_ovf_at_d", overflow, 0);
    chk("t4_no_valid", read_data_valid, 0);
    chk("t4_empty", fifo_empty, 1);
    cyc(2'b01, 2'b00, 16'h00EE, 16'h0);
    chk("t4_ovf_set", overflow, 1);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(model({8'(8'h60 + i), 8'(8'h50 + i)},
                            {8'(8'h80 + i), 8'(8'h70 + i)}, 2'b00));
      cyc(2'b10, 2'b11, {8'(8'h60 + i), 8'h00}, {8'(8'h80 + i), 8'(8'h70 + i)});
    end
    repeat (3) cyc(2'b00, 2'b00, 16'h0, 16'h0);
    chk("t4_ovf_sticky", overflow, 1);
    chk("t4_drained_empty", fifo_empty, 1);
    reset = 1'b1;
    repeat (2) cyc(2'b00, 2'b00, 16'h0, 16'h0);
    reset = 1'b0;
    repeat (2) cyc(2'b00, 2'b00, 16'h0, 16'h0);
    chk("t4_ovf_cleared", overflow, 0);

    // 40-word continuous stream with pointer wrap
    fr = 2'b10;
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back(model({8'(i * 3), 8'(i)}, {8'(255 - i), 8'(i + 100)}, fr));
      cyc(2'b11, 2'b11, {8'(i * 3), 8'(i)}, {8'(255 - i), 8'(i + 100)});
      if (i >= 2) chk("t5_stream_valid", read_data_valid, 1);
    end
    cyc(2'b00, 2'b00, 16'h0, 16'h0);
    chk("t5_tail_valid_a", read_data_valid, 1);
    cyc(2'b00, 2'b00, 16'h0, 16'h0);
    chk("t5_tail_valid_b", read_data_valid, 1);
    cyc(2'b00, 2'b00, 16'h0, 16'h0);
    chk("t5_end_valid", read_data_valid, 0);
    chk("t5_no_overflow", overflow, 0);
    fr = 2'b00;

    // Reset mid-burst: words 0..4 emerge before reset_r1 takes effect
    for (int i = 0; i < 6; i++) begin
      if (i < 5) exp_q.push_back({8'(8'hC0 + i), 8'(8'hD0 + i), 8'(8'hE0 + i), 8'(8'hF0 + i)});
      cyc(2'b11, 2'b11, {8'(8'hC0 + i), 8'(8'hD0 + i)}, {8'(8'hE0 + i), 8'(8'hF0 + i)});
    end
    reset = 1'b1;
    cyc(2'b00, 2'b00, 16'h0, 16'h0);
    chk("t6_last_valid", read_data_valid, 1);
    cyc(2'b00, 2'b00, 16'h0, 16'h0);
    chk("t6_rst_valid", read_data_valid, 0);
    chk("t6_rst_rise", out_rise, 0);
    chk("t6_rst_fall", out_fall, 0);
    chk("t6_rst_empty", fifo_empty, 1);
    reset = 1'b0;
    repeat (4) cyc(2'b00, 2'b00, 16'h0, 16'h0);
    chk("t6_post_valid", read_data_valid, 0);
    chk("t6_post_empty", fifo_empty, 1);

    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
